// File: rtl/lfsr_pkg.sv
// lfsr_pkg: definitions shared by the 14-bit XNOR noise LFSR generator and
// its receive-side sync checker.
//   LFSR_N             - register length
//   LFSR_TAP0..3       - feedback taps (history index, 0 = newest bit)
//   lfsr_chk_state_t   - checker FSM state encoding
//   lfsr_predict_bit() - next feedback bit for a given history
package lfsr_pkg;

    localparam int LFSR_N    = 14;
    localparam int LFSR_TAP0 = 13;
    localparam int LFSR_TAP1 = 12;
    localparam int LFSR_TAP2 = 11;
    localparam int LFSR_TAP3 = 1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } lfsr_chk_state_t;

    // XNOR feedback: the all-ones state maps onto itself (lockup state).
    function automatic logic lfsr_predict_bit(input logic [LFSR_N-1:0] h);
        return ~(h[LFSR_TAP0] ^ h[LFSR_TAP1] ^ h[LFSR_TAP2] ^ h[LFSR_TAP3]);
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// lfsr_predict: combinational map from the last LFSR_N received/flywheeled
// bits to the bit the generator will emit next.
//   hist_i - bit history, hist_i[0] newest
//   pred_o - predicted next bit
module lfsr_predict
    import lfsr_pkg::*;
(
    input  logic [LFSR_N-1:0] hist_i,
    output logic              pred_o
);

    assign pred_o = lfsr_predict_bit(hist_i);

endmodule

// File: rtl/lfsr_sync_checker.sv
// lfsr_sync_checker: self-synchronising checker for the 14-bit XNOR noise
// LFSR stream. Fills a local history, tracks until LOCK_COUNT consecutive
// bits are predicted correctly, then flywheels and flags each mispredicted
// bit. LOSS_COUNT consecutive misses while locked restart acquisition.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - in_bit is valid this cycle; low freezes all state
//   in_bit      - received stream bit, oldest first
//   err_clr     - synchronous clear of err_count (wins over an increment)
//   locked      - FSM is in LOCKED
//   err_pulse   - one cycle per mispredicted locked beat
//   err_count   - saturating locked-mode error count
//   state_o     - FSM state for debug
//
// Build option: LFSR_CHK_ERRCNT_EN defined implements err_count and err_clr;
// undefined ties err_count to 0 and ignores err_clr.
//
// state  | meaning
// FILL   | shifting in the first N bits, no predictions yet
// TRACK  | shifting received bits, counting consecutive correct predictions
// LOCKED | shifting predicted bits (flywheel), counting and flagging misses
module lfsr_sync_checker
    import lfsr_pkg::*;
#(
    parameter int N          = LFSR_N,
    parameter int LOCK_COUNT = 32,
    parameter int LOSS_COUNT = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state_o
);

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_COUNT - 1);

    lfsr_chk_state_t    state_q;
    logic [N-1:0]       h_q;
    logic [FILL_W-1:0]  fill_q;
    logic [MATCH_W-1:0] match_q;
    logic [MISS_W-1:0]  miss_q;
    logic               locked_q;
    logic               err_pulse_q;

    logic pred;
    logic bit_ok;
    logic h_stuck;
    logic lock_miss;

    lfsr_predict u_predict (
        .hist_i (h_q),
        .pred_o (pred)
    );

    assign bit_ok    = (in_bit == pred);
    // All-ones history predicts 1 forever; a stuck-high line would lock.
    assign h_stuck   = &h_q;
    assign lock_miss = in_valid && (state_q == ST_LOCKED) && !bit_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FILL;
            h_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= lock_miss;
            if (in_valid) begin
                unique case (state_q)
                    ST_FILL: begin
                        h_q    <= {h_q[N-2:0], in_bit};
                        fill_q <= fill_q + 1'b1;
                        if (fill_q == FILL_LAST) begin
                            match_q <= '0;
                            state_q <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        h_q <= {h_q[N-2:0], in_bit};
                        if (h_stuck || !bit_ok) begin
                            match_q <= '0;
                        end else begin
                            match_q <= match_q + 1'b1;
                            if (match_q == MATCH_LAST) begin
                                miss_q   <= '0;
                                locked_q <= 1'b1;
                                state_q  <= ST_LOCKED;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // Flywheel: a channel error must not corrupt the history.
                        h_q <= {h_q[N-2:0], pred};
                        if (bit_ok) begin
                            miss_q <= '0;
                        end else if (miss_q == MISS_LAST) begin
                            fill_q   <= '0;
                            match_q  <= '0;
                            miss_q   <= '0;
                            locked_q <= 1'b0;
                            state_q  <= ST_FILL;
                        end else begin
                            miss_q <= miss_q + 1'b1;
                        end
                    end
                    default: begin
                        locked_q <= 1'b0;
                        state_q  <= ST_FILL;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_CHK_ERRCNT_EN
    logic [CNT_W-1:0] err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (err_clr) begin
            err_count_q <= '0;
        end else if (lock_miss && !(&err_count_q)) begin
            err_count_q <= err_count_q + 1'b1;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_lfsr_sync_checker.sv
module tb_lfsr_sync_checker;

`ifdef LFSR_CHK_ERRCNT_EN
    localparam bit ERRCNT_EN = 1'b1;
`else
    localparam bit ERRCNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_bit;
    logic        err_clr;
    logic        locked16;
    logic        pulse16;
    logic [15:0] count16;
    logic [1:0]  state16;
    logic        locked4;
    logic        pulse4;
    logic [3:0]  count4;
    logic [1:0]  state4;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    lfsr_sync_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .err_clr   (err_clr),
        .locked    (locked16),
        .err_pulse (pulse16),
        .err_count (count16),
        .state_o   (state16)
    );

    lfsr_sync_checker #(.CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .err_clr   (err_clr),
        .locked    (locked4),
        .err_pulse (pulse4),
        .err_count (count4),
        .state_o   (state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference generator ----------------
    logic [13:0] g;
    function automatic bit gen_bit();
        bit nb;
        nb = !(g[13] ^ g[12] ^ g[11] ^ g[1]);
        g  = {g[12:0], nb};
        return nb;
    endfunction

    // ---------------- behavioural model ----------------
    // mode: 0 filling, 1 tracking, 2 locked (the spec's state numbers)
    bit hist [14];
    int m_mode, m_fill, m_match, m_miss, m_err16, m_err4;
    bit exp_pulse;

    function automatic void push_hist(input bit b);
        for (int i = 13; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = b;
    endfunction

    function automatic bit all_ones();
        for (int i = 0; i < 14; i++) if (!hist[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 14; i++) hist[i] = 1'b0;
        m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
        m_err16 = 0; m_err4 = 0; exp_pulse = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input bit b, input bit clr);
        bit p, good;
        exp_pulse = 1'b0;
        if (clr) begin m_err16 = 0; m_err4 = 0; end
        if (!v) return;
        p = !(hist[13] ^ hist[12] ^ hist[11] ^ hist[1]);
        if (m_mode == 0) begin
            push_hist(b);
            m_fill++;
            if (m_fill == 14) begin m_mode = 1; m_match = 0; end
        end else if (m_mode == 1) begin
            good = (b == p) && !all_ones();
            push_hist(b);
            m_match = good ? m_match + 1 : 0;
            if (m_match == 32) begin m_mode = 2; m_miss = 0; end
        end else begin
            push_hist(p);
            if (b != p) begin
                exp_pulse = 1'b1;
                if (!clr) begin
                    if (m_err16 < 65535) m_err16++;
                    if (m_err4 < 15) m_err4++;
                end
                m_miss++;
                if (m_miss == 8) begin
                    m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
                end
            end else begin
                m_miss = 0;
            end
        end
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step(in_valid, in_bit, err_clr);
        #1;
        if (cmp_en) begin
            chk("cyc_locked",  locked16, (m_mode == 2));
            chk("cyc_state",   state16,  m_mode);
            chk("cyc_pulse",   pulse16,  exp_pulse);
            chk("cyc_count",   count16,  ERRCNT_EN ? m_err16 : 0);
            chk("cyc_locked4", locked4,  (m_mode == 2));
            chk("cyc_state4",  state4,   m_mode);
            chk("cyc_pulse4",  pulse4,   exp_pulse);
            chk("cyc_count4",  count4,   ERRCNT_EN ? m_err4 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input bit v, input bit b, input bit clr);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        err_clr  = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0; in_bit = 1'b0; err_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [5:0] first6;
        int pulses, nv;
        bit saw_lock;

        rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_locked", locked16, 0);
        chk("rst_state",  state16,  0);
        chk("rst_pulse",  pulse16,  0);
        chk("rst_count",  count16,  0);
        chk("rst_count4", count4,   0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        g = '0;
        for (int i = 5; i >= 0; i--) first6[i] = gen_bit();
        chk("gen_first6", first6, 6'b110011);
        g = '0;

        // clean lock: locked visible right after valid beat 46
        for (int i = 1; i <= 46; i++) begin
            beat(1'b1, gen_bit(), 1'b0);
            if (i == 45) chk("lock_beat45", locked16, 0);
            if (i == 46) begin
                chk("lock_beat46", locked16, 1);
                chk("lock_state",  state16,  2);
            end
        end
        repeat (20000 - 46) beat(1'b1, gen_bit(), 1'b0);
        chk("long_locked", locked16, 1);
        chk("long_count",  count16,  0);

        // single flipped bit
        beat(1'b1, !gen_bit(), 1'b0);
        pulses = int'(pulse16);
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, gen_bit(), 1'b0);
            pulses += int'(pulse16);
        end
        chk("flip_pulses", pulses, 1);
        chk("flip_count",  count16, ERRCNT_EN ? 1 : 0);
        chk("flip_locked", locked16, 1);

        // eight consecutive wrong bits force loss
        for (int i = 1; i <= 8; i++) begin
            beat(1'b1, !gen_bit(), 1'b0);
            if (i == 7) chk("loss_beat7", locked16, 1);
            if (i == 8) begin
                chk("loss_beat8", locked16, 0);
                chk("loss_state", state16,  0);
            end
        end
        for (int i = 1; i <= 46; i++) begin
            beat(1'b1, gen_bit(), 1'b0);
            if (i == 45) chk("relock_45", locked16, 0);
            if (i == 46) chk("relock_46", locked16, 1);
        end
        chk("relock_count", count16, ERRCNT_EN ? 9 : 0);

        // clear, then 20 isolated errors: 4-bit counter saturates at 15
        beat(1'b1, gen_bit(), 1'b1);
        chk("clr_count",  count16, 0);
        chk("clr_count4", count4,  0);
        for (int e = 1; e <= 20; e++) begin
            beat(1'b1, !gen_bit(), 1'b0);
            repeat (3) beat(1'b1, gen_bit(), 1'b0);
            if (e == 15) chk("sat_at15", count4, ERRCNT_EN ? 15 : 0);
        end
        chk("sat_count4", count4,  ERRCNT_EN ? 15 : 0);
        chk("sat_count",  count16, ERRCNT_EN ? 20 : 0);
        chk("sat_locked", locked16, 1);

        // clear on the same beat as an error wins
        beat(1'b1, !gen_bit(), 1'b1);
        chk("clrerr_pulse",  pulse16, 1);
        chk("clrerr_count",  count16, 0);
        chk("clrerr_count4", count4,  0);
        repeat (3) beat(1'b1, gen_bit(), 1'b0);
        beat(1'b1, !gen_bit(), 1'b0);
        chk("after_clr_count", count16, ERRCNT_EN ? 1 : 0);

        // asynchronous reset mid-operation
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", locked16, 0);
        chk("arst_state",  state16,  0);
        chk("arst_count",  count16,  0);
        chk("arst_pulse",  pulse16,  0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // clean stream with random gaps, garbage on in_bit during gaps
        g  = '0;
        nv = 0;
        while (nv < 400) begin
            if ($urandom_range(0, 3) == 0) begin
                beat(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                beat(1'b1, gen_bit(), 1'b0);
                nv++;
                if (nv == 45) chk("gap_lock45", locked16, 0);
                if (nv == 46) chk("gap_lock46", locked16, 1);
            end
        end
        chk("gap_count", count16, 0);

        // stuck-high line never locks
        do_reset();
        saw_lock = 1'b0;
        repeat (200) begin
            beat(1'b1, 1'b1, 1'b0);
            if (locked16) saw_lock = 1'b1;
        end
        chk("stuck_never_locked", saw_lock, 0);
        chk("stuck_state", state16, 1);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
